// File: rtl/spi_slave_tx_buf_pkg.sv
// Shared lane-mode and FSM types for the SPI slave transmit path.
// lanes_of() maps a lane mode to the number of bits shifted per beat.
package spi_slave_pkg;

    typedef enum logic [1:0] {
        LANE_SINGLE = 2'd0,
        LANE_DUAL   = 2'd1,
        LANE_QUAD   = 2'd2,
        LANE_RSVD   = 2'd3
    } lane_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2
    } tx_state_e;

    localparam int SPI_TX_DEFAULT_BEATS = 7;

    // The reserved encoding behaves as single lane.
    function automatic logic [2:0] lanes_of(input lane_mode_e mode);
        case (mode)
            LANE_DUAL: lanes_of = 3'd2;
            LANE_QUAD: lanes_of = 3'd4;
            default:   lanes_of = 3'd1;
        endcase
    endfunction

endpackage

// File: rtl/spi_slave_tx_buf_fifo.sv
// Synchronous FIFO buffering transmit words; push ignored when full, pop ignored when empty.
// Read data is the head entry, valid combinationally whenever empty_o is low.
module spi_slave_tx_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       push_dat_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       pop_dat_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] level_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      level_q;
    logic             do_push;
    logic             do_pop;

    assign full_o    = (level_q == (AW+1)'(DEPTH));
    assign empty_o   = (level_q == '0);
    assign level_o   = level_q;
    assign pop_dat_o = mem_q[rd_ptr_q];
    assign do_push   = push_i & ~full_o;
    assign do_pop    = pop_i & ~empty_o;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/spi_slave_tx_buf.sv
// Buffered SPI slave transmitter: oversampled sclk/cs, FIFO-fed shifter on 1/2/4 lanes.
// Optional SPI_SLAVE_TX_BUF_LSB_FIRST_EN adds lsb_first_i for LSB-first shifting.
module spi_slave_tx_buf
    import spi_slave_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          sclk_i,
    input  logic                          cs_i,
    input  lane_mode_e                    lane_mode_i,
    input  logic [$clog2(DATA_WIDTH)-1:0] beats_i,
    input  logic                          beats_upd_i,
    input  logic [DATA_WIDTH-1:0]         data_i,
    input  logic                          data_valid_i,
`ifdef SPI_SLAVE_TX_BUF_LSB_FIRST_EN
    input  logic                          lsb_first_i,
`endif
    output logic                          data_ready_o,
    output logic [3:0]                    sdo_o,
    output logic                          sdo_oe_o,
    output logic                          done_o,
    output logic                          underrun_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

    localparam int CW = $clog2(DATA_WIDTH);

    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic                   sclk_prev_q;
    logic                   cs_prev_q;
    logic                   sclk_s;
    logic                   cs_s;
    logic                   cs_fall;
    logic                   shift_evt;

    tx_state_e              state_q;
    logic [DATA_WIDTH-1:0]  sr_q;
    logic [DATA_WIDTH-1:0]  sr_shift_d;
    logic [CW-1:0]          cnt_q;
    logic [CW-1:0]          target_q;
    lane_mode_e             lane_q;
    logic                   lsb_q;
    logic                   oe_q;
    logic                   done_q;
    logic                   underrun_q;
    logic                   word_end;
    logic                   load_now;

    logic                   fifo_push;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [DATA_WIDTH-1:0]  fifo_dat;

    spi_slave_tx_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (fifo_push),
        .push_dat_i (data_i),
        .pop_i      (load_now),
        .pop_dat_o  (fifo_dat),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .level_o    (fifo_level_o)
    );

    assign data_ready_o = ~fifo_full;
    assign fifo_push    = data_valid_i & data_ready_o;

    // cs resets to inactive so a reset never looks like a cs falling edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_i};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_i};
            sclk_prev_q <= sclk_s;
            cs_prev_q   <= cs_s;
        end
    end

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign cs_fall   = cs_prev_q & ~cs_s;
    assign shift_evt = sclk_prev_q & ~sclk_s & ~cs_s;

    // A counter sitting at its maximum also closes the word, covering a target lowered below it.
    assign word_end = (state_q == ST_SHIFT) && shift_evt &&
                      ((cnt_q == target_q) || (cnt_q == '1));
    assign load_now = ((state_q == ST_LOAD) && !cs_s) || word_end;

`ifdef SPI_SLAVE_TX_BUF_LSB_FIRST_EN
    assign sr_shift_d = lsb_q ? (sr_q >> lanes_of(lane_q)) : (sr_q << lanes_of(lane_q));
`else
    assign sr_shift_d = sr_q << lanes_of(lane_q);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            target_q <= CW'(SPI_TX_DEFAULT_BEATS);
        end else if (beats_upd_i) begin
            target_q <= beats_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            sr_q       <= '0;
            cnt_q      <= '0;
            lane_q     <= LANE_SINGLE;
            lsb_q      <= 1'b0;
            oe_q       <= 1'b0;
            done_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    sr_q  <= '0;
                    cnt_q <= '0;
                    oe_q  <= 1'b0;
                    if (cs_fall) begin
                        state_q    <= ST_LOAD;
                        oe_q       <= 1'b1;
                        underrun_q <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    cnt_q <= '0;
                    if (cs_s) begin
                        state_q <= ST_IDLE;
                        oe_q    <= 1'b0;
                        sr_q    <= '0;
                    end else begin
                        state_q <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (cs_s) begin
                        state_q <= ST_IDLE;
                        oe_q    <= 1'b0;
                        sr_q    <= '0;
                        cnt_q   <= '0;
                    end else if (shift_evt) begin
                        if (word_end) begin
                            done_q <= 1'b1;
                            cnt_q  <= '0;
                        end else begin
                            sr_q  <= sr_shift_d;
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase

            // Word load shared by the first word after cs and every back-to-back word.
            if (load_now) begin
                sr_q   <= fifo_empty ? '0 : fifo_dat;
                lane_q <= lane_mode_i;
`ifdef SPI_SLAVE_TX_BUF_LSB_FIRST_EN
                lsb_q  <= lsb_first_i;
`else
                lsb_q  <= 1'b0;
`endif
                if (fifo_empty) begin
                    underrun_q <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        sdo_o = '0;
`ifdef SPI_SLAVE_TX_BUF_LSB_FIRST_EN
        if (lsb_q) begin
            case (lane_q)
                LANE_QUAD: sdo_o      = sr_q[3:0];
                LANE_DUAL: sdo_o[1:0] = sr_q[1:0];
                default:   sdo_o[0]   = sr_q[0];
            endcase
        end else
`endif
        begin
            case (lane_q)
                LANE_QUAD: sdo_o      = sr_q[DATA_WIDTH-1 -: 4];
                LANE_DUAL: sdo_o[1:0] = sr_q[DATA_WIDTH-1 -: 2];
                default:   sdo_o[0]   = sr_q[DATA_WIDTH-1];
            endcase
        end
    end

    assign sdo_oe_o   = oe_q;
    assign done_o     = done_q;
    assign underrun_o = underrun_q;

endmodule

// File: tb/tb_spi_slave_tx_buf.sv
// Bench for spi_slave_tx_buf: SPI master model on sclk/cs, expected lane data from word arithmetic.
module tb_spi_slave_tx_buf;
    import spi_slave_pkg::*;

    logic        clk;
    logic        rst;
    logic        sclk_i;
    logic        cs_i;
    lane_mode_e  lane_mode_i;
    logic [4:0]  beats_i;
    logic        beats_upd_i;
    logic [31:0] data_i;
    logic        data_valid_i;
    logic        data_ready_o;
    logic [3:0]  sdo_o;
    logic        sdo_oe_o;
    logic        done_o;
    logic        underrun_o;
    logic [2:0]  fifo_level_o;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;

    spi_slave_tx_buf #(
        .DATA_WIDTH  (32),
        .FIFO_DEPTH  (4),
        .SYNC_STAGES (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sclk_i       (sclk_i),
        .cs_i         (cs_i),
        .lane_mode_i  (lane_mode_i),
        .beats_i      (beats_i),
        .beats_upd_i  (beats_upd_i),
        .data_i       (data_i),
        .data_valid_i (data_valid_i),
`ifdef SPI_SLAVE_TX_BUF_LSB_FIRST_EN
        .lsb_first_i  (1'b0),
`endif
        .data_ready_o (data_ready_o),
        .sdo_o        (sdo_o),
        .sdo_oe_o     (sdo_oe_o),
        .done_o       (done_o),
        .underrun_o   (underrun_o),
        .fifo_level_o (fifo_level_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (done_o === 1'b1) done_cnt = done_cnt + 1;

    function automatic int lanes_for(input int mode);
        return (mode == 2) ? 4 : (mode == 1) ? 2 : 1;
    endfunction

    // Beat k of an MSB-first word carries bits [W-1-l*k -: l].
    function automatic logic [3:0] exp_chunk(input logic [31:0] w, input int l, input int k);
        logic [31:0] t;
        t = w << (l * k);
        return 4'(t >> (32 - l));
    endfunction

    task automatic set_beats(input int b);
        beats_i     = 5'(b);
        beats_upd_i = 1'b1;
        @(negedge clk);
        beats_upd_i = 1'b0;
    endtask

    task automatic push_word(input logic [31:0] w);
        int n = 0;
        data_i       = w;
        data_valid_i = 1'b1;
        while (data_ready_o !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n == 50) begin
            checks++;
            failures++;
            $display("FAIL push_timeout: ready=%b required 1", data_ready_o);
        end
        @(negedge clk);
        data_valid_i = 1'b0;
    endtask

    // One SPI beat: master samples before the rising edge, slave shifts on the falling edge.
    task automatic spi_beat(output logic [3:0] s);
        repeat (5) @(negedge clk);
        s      = sdo_o;
        sclk_i = 1'b1;
        repeat (5) @(negedge clk);
        sclk_i = 1'b0;
    endtask

    task automatic cs_start();
        cs_i = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic cs_stop();
        repeat (6) @(negedge clk);
        cs_i = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks += 6;
        if (sdo_o !== 4'h0)        begin failures++; $display("FAIL reset_sdo: got %h want 0", sdo_o); end
        if (sdo_oe_o !== 1'b0)     begin failures++; $display("FAIL reset_oe: got %b want 0", sdo_oe_o); end
        if (done_o !== 1'b0)       begin failures++; $display("FAIL reset_done: got %b want 0", done_o); end
        if (underrun_o !== 1'b0)   begin failures++; $display("FAIL reset_underrun: got %b want 0", underrun_o); end
        if (data_ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b want 1", data_ready_o); end
        if (fifo_level_o !== 3'd0) begin failures++; $display("FAIL reset_level: got %0d want 0", fifo_level_o); end
    endtask

    task automatic test_single();
        logic [31:0] w = 32'hA5A5_0F0F;
        logic [3:0]  s;
        int d0;
        lane_mode_i = LANE_SINGLE;
        set_beats(31);
        push_word(w);
        checks++;
        if (fifo_level_o !== 3'd1) begin failures++; $display("FAIL single_level_pre: got %0d want 1", fifo_level_o); end
        d0 = done_cnt;
        cs_start();
        checks += 2;
        if (fifo_level_o !== 3'd0) begin failures++; $display("FAIL single_level_post: got %0d want 0", fifo_level_o); end
        if (sdo_oe_o !== 1'b1)     begin failures++; $display("FAIL single_oe: got %b want 1", sdo_oe_o); end
        for (int k = 0; k < 32; k++) begin
            spi_beat(s);
            checks++;
            if (s !== exp_chunk(w, 1, k)) begin failures++; $display("FAIL single_bit%0d: got %h want %h", k, s, exp_chunk(w, 1, k)); end
        end
        cs_stop();
        checks += 2;
        if (done_cnt - d0 != 1) begin failures++; $display("FAIL single_done: got %0d pulses want 1", done_cnt - d0); end
        if (sdo_oe_o !== 1'b0)  begin failures++; $display("FAIL single_oe_idle: got %b want 0", sdo_oe_o); end
    endtask

    task automatic test_quad();
        logic [31:0] w [2];
        logic [3:0]  s;
        int d0;
        w[0] = 32'h1234_5678;
        w[1] = 32'h9ABC_DEF0;
        lane_mode_i = LANE_QUAD;
        set_beats(7);
        push_word(w[0]);
        push_word(w[1]);
        d0 = done_cnt;
        cs_start();
        for (int k = 0; k < 16; k++) begin
            spi_beat(s);
            checks++;
            if (s !== exp_chunk(w[k/8], 4, k % 8)) begin failures++; $display("FAIL quad_nibble%0d: got %h want %h", k, s, exp_chunk(w[k/8], 4, k % 8)); end
        end
        cs_stop();
        checks++;
        if (done_cnt - d0 != 2) begin failures++; $display("FAIL quad_done: got %0d pulses want 2", done_cnt - d0); end
    endtask

    task automatic test_underrun_dual();
        logic [31:0] w = 32'hC3F0_5A96;
        logic [3:0]  s;
        lane_mode_i = LANE_DUAL;
        set_beats(15);
        cs_start();
        checks++;
        if (underrun_o !== 1'b1) begin failures++; $display("FAIL underrun_set: got %b want 1", underrun_o); end
        for (int k = 0; k < 4; k++) begin
            spi_beat(s);
            checks++;
            if (s !== 4'h0) begin failures++; $display("FAIL underrun_sdo%0d: got %h want 0", k, s); end
        end
        cs_stop();
        checks++;
        if (underrun_o !== 1'b1) begin failures++; $display("FAIL underrun_sticky: got %b want 1", underrun_o); end
        push_word(w);
        cs_start();
        checks++;
        if (underrun_o !== 1'b0) begin failures++; $display("FAIL underrun_clear: got %b want 0", underrun_o); end
        for (int k = 0; k < 16; k++) begin
            spi_beat(s);
            checks++;
            if (s !== exp_chunk(w, 2, k)) begin failures++; $display("FAIL dual_beat%0d: got %h want %h", k, s, exp_chunk(w, 2, k)); end
        end
        cs_stop();
    endtask

    task automatic test_full_and_abort();
        logic [31:0] w [4];
        logic [3:0]  s;
        int d0;
        int n;
        lane_mode_i = LANE_SINGLE;
        set_beats(31);
        for (int i = 0; i < 4; i++) begin
            w[i] = $urandom;
            push_word(w[i]);
        end
        checks += 2;
        if (data_ready_o !== 1'b0) begin failures++; $display("FAIL full_ready: got %b want 0", data_ready_o); end
        if (fifo_level_o !== 3'd4) begin failures++; $display("FAIL full_level: got %0d want 4", fifo_level_o); end
        data_i       = 32'hDEAD_BEEF;
        data_valid_i = 1'b1;
        repeat (5) @(negedge clk);
        data_valid_i = 1'b0;
        checks++;
        if (fifo_level_o !== 3'd4) begin failures++; $display("FAIL full_stall: got %0d want 4", fifo_level_o); end
        d0   = done_cnt;
        cs_i = 1'b0;
        n    = 0;
        while (fifo_level_o !== 3'd3 && n < 15) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n == 15 || data_ready_o !== 1'b1) begin failures++; $display("FAIL full_ready_after_pop: level=%0d ready=%b want 3/1", fifo_level_o, data_ready_o); end
        for (int k = 0; k < 32; k++) begin
            spi_beat(s);
            checks++;
            if (s !== exp_chunk(w[0], 1, k)) begin failures++; $display("FAIL full_w0_bit%0d: got %h want %h", k, s, exp_chunk(w[0], 1, k)); end
        end
        cs_stop();
        checks += 2;
        if (done_cnt - d0 != 1)    begin failures++; $display("FAIL full_done: got %0d want 1", done_cnt - d0); end
        if (fifo_level_o !== 3'd2) begin failures++; $display("FAIL full_level_after: got %0d want 2", fifo_level_o); end
        // Word 1 was popped at the boundary and lost with cs; word 2 is next.
        d0 = done_cnt;
        cs_start();
        for (int k = 0; k < 10; k++) begin
            spi_beat(s);
            checks++;
            if (s !== exp_chunk(w[2], 1, k)) begin failures++; $display("FAIL abort_w2_bit%0d: got %h want %h", k, s, exp_chunk(w[2], 1, k)); end
        end
        cs_stop();
        checks += 2;
        if (done_cnt != d0)        begin failures++; $display("FAIL abort_done: got %0d pulses want 0", done_cnt - d0); end
        if (fifo_level_o !== 3'd1) begin failures++; $display("FAIL abort_level: got %0d want 1", fifo_level_o); end
        cs_start();
        for (int k = 0; k < 32; k++) begin
            spi_beat(s);
            checks++;
            if (s !== exp_chunk(w[3], 1, k)) begin failures++; $display("FAIL abort_w3_bit%0d: got %h want %h", k, s, exp_chunk(w[3], 1, k)); end
        end
        cs_stop();
        checks++;
        if (done_cnt - d0 != 1) begin failures++; $display("FAIL abort_next_done: got %0d want 1", done_cnt - d0); end
    endtask

    task automatic test_beats_update();
        logic [31:0] wa = $urandom;
        logic [31:0] wb = $urandom;
        logic [3:0]  s;
        int d0;
        lane_mode_i = LANE_SINGLE;
        set_beats(31);
        push_word(wa);
        push_word(wb);
        d0 = done_cnt;
        cs_start();
        for (int k = 0; k < 8; k++) begin
            spi_beat(s);
            checks++;
            if (s !== exp_chunk(wa, 1, k)) begin failures++; $display("FAIL upd_wa_bit%0d: got %h want %h", k, s, exp_chunk(wa, 1, k)); end
            if (k == 4) set_beats(7);
            if (k == 6) begin
                repeat (4) @(negedge clk);
                checks++;
                if (done_cnt != d0) begin failures++; $display("FAIL upd_early_done: got %0d want 0", done_cnt - d0); end
            end
        end
        repeat (4) @(negedge clk);
        checks++;
        if (done_cnt - d0 != 1) begin failures++; $display("FAIL upd_short_done: got %0d want 1", done_cnt - d0); end
        // Target lowered below the running count: word runs to the counter maximum.
        for (int k = 0; k < 32; k++) begin
            spi_beat(s);
            checks++;
            if (s !== exp_chunk(wb, 1, k)) begin failures++; $display("FAIL upd_wb_bit%0d: got %h want %h", k, s, exp_chunk(wb, 1, k)); end
            if (k == 5) set_beats(3);
            if (k == 30) begin
                repeat (4) @(negedge clk);
                checks++;
                if (done_cnt - d0 != 1) begin failures++; $display("FAIL upd_wrap_early: got %0d want 1", done_cnt - d0); end
            end
        end
        cs_stop();
        checks++;
        if (done_cnt - d0 != 2) begin failures++; $display("FAIL upd_wrap_done: got %0d want 2", done_cnt - d0); end
    endtask

    task automatic test_random();
        logic [31:0] q [$];
        logic [3:0]  s;
        int mode, l, b, n, d0;
        for (int r = 0; r < 6; r++) begin
            mode = $urandom_range(0, 3);
            l    = lanes_for(mode);
            b    = $urandom_range(1, 32 / l);
            n    = $urandom_range(1, 3);
            lane_mode_i = lane_mode_e'(mode);
            set_beats(b - 1);
            q.delete();
            for (int i = 0; i < n; i++) begin
                q.push_back($urandom);
                push_word(q[i]);
            end
            d0 = done_cnt;
            cs_start();
            for (int i = 0; i < n; i++) begin
                for (int k = 0; k < b; k++) begin
                    spi_beat(s);
                    checks++;
                    if (s !== exp_chunk(q[i], l, k)) begin failures++; $display("FAIL rand_r%0d_w%0d_b%0d: got %h want %h", r, i, k, s, exp_chunk(q[i], l, k)); end
                end
            end
            cs_stop();
            checks++;
            if (done_cnt - d0 != n) begin failures++; $display("FAIL rand_r%0d_done: got %0d want %0d", r, done_cnt - d0, n); end
        end
    endtask

    task automatic test_rst_mid();
        logic [3:0] s;
        lane_mode_i = LANE_QUAD;
        set_beats(7);
        push_word(32'hFFFF_FFFF);
        push_word(32'h8765_4321);
        cs_start();
        for (int k = 0; k < 3; k++) spi_beat(s);
        rst = 1'b1;
        @(negedge clk);
        checks += 6;
        if (sdo_o !== 4'h0)        begin failures++; $display("FAIL rstmid_sdo: got %h want 0", sdo_o); end
        if (sdo_oe_o !== 1'b0)     begin failures++; $display("FAIL rstmid_oe: got %b want 0", sdo_oe_o); end
        if (done_o !== 1'b0)       begin failures++; $display("FAIL rstmid_done: got %b want 0", done_o); end
        if (underrun_o !== 1'b0)   begin failures++; $display("FAIL rstmid_underrun: got %b want 0", underrun_o); end
        if (data_ready_o !== 1'b1) begin failures++; $display("FAIL rstmid_ready: got %b want 1", data_ready_o); end
        if (fifo_level_o !== 3'd0) begin failures++; $display("FAIL rstmid_level: got %0d want 0", fifo_level_o); end
        cs_i = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        rst          = 1'b1;
        sclk_i       = 1'b0;
        cs_i         = 1'b1;
        lane_mode_i  = LANE_SINGLE;
        beats_i      = 5'd0;
        beats_upd_i  = 1'b0;
        data_i       = 32'h0;
        data_valid_i = 1'b0;
        test_reset();
        test_single();
        test_quad();
        test_underrun_dual();
        test_full_and_abort();
        test_beats_update();
        test_random();
        test_rst_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
